// File: rtl/da_pkg.sv
// Shared constants for the DA FIR output stage: result width and parameter defaults.
package da_pkg;
   localparam int DA_W          = 17;
   localparam int FRAC_BITS_DEF = 7;
   localparam int OUT_W_DEF     = 8;
   localparam int DEPTH_DEF     = 4;
endpackage

// File: rtl/da_sync_fifo.sv
// First-word fall-through FIFO; a full FIFO still accepts a write when a pop happens in the same cycle.
module da_sync_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic         clk_bit,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_data,
   output logic         rd_vld,
   output logic         wr_drop
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         empty, full, push, pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wp_q == rp_q);
   assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign pop     = !empty && rd_rdy;
   assign push    = wr_en && (!full || pop);
   assign wr_drop = wr_en && full && !pop;

   assign wp_d = wp_q + (AW+1)'(push);
   assign rp_d = rp_q + (AW+1)'(pop);

   assign rd_vld  = !empty;
   assign rd_data = empty ? '0 : mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk_bit) begin
      if (push) mem_q[wp_q[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/da_out_stage.sv
// DA FIR output stage: round-half-up, saturate to OUT_W, queue in a FIFO, track drops and saturations.
module da_out_stage
   import da_pkg::*;
#(
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int OUT_W     = OUT_W_DEF,
   parameter int DEPTH     = DEPTH_DEF
) (
   input  logic                    clk_bit,
   input  logic                    rst_n,
   input  logic signed [DA_W-1:0]  sum_in,
   input  logic                    sum_vld,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_sat,
   output logic                    ovf_flag,
   output logic [7:0]              sat_cnt,
   input  logic                    clr
);
   localparam int RW = DA_W + 1;
   localparam logic signed [RW-1:0] MAX_V = RW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

   logic signed [RW-1:0]    r_q, r_d, sh;
   logic                    vld1_q;
   logic                    sat_s, drop;
   logic signed [OUT_W-1:0] res_s;
   logic [7:0]              sat_cnt_q, sat_cnt_d;
   logic                    ovf_q, ovf_d;

   assign r_d = {sum_in[DA_W-1], sum_in} + RW'(1 << (FRAC_BITS - 1));

   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '0;
         vld1_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         vld1_q <= sum_vld;
      end
   end

   assign sh = r_q >>> FRAC_BITS;

   always_comb begin
      sat_s = 1'b0;
      res_s = sh[OUT_W-1:0];
      if (sh > MAX_V) begin
         sat_s = 1'b1;
         res_s = MAX_V[OUT_W-1:0];
      end else if (sh < MIN_V) begin
         sat_s = 1'b1;
         res_s = MIN_V[OUT_W-1:0];
      end
   end

   da_sync_fifo #(.W(OUT_W + 1), .DEPTH(DEPTH)) u_fifo (
      .clk_bit (clk_bit),
      .rst_n   (rst_n),
      .wr_en   (vld1_q),
      .wr_data ({sat_s, res_s}),
      .rd_rdy  (out_ready),
      .rd_data ({out_sat, out_data}),
      .rd_vld  (out_valid),
      .wr_drop (drop)
   );

   // Dropped results still count toward sat_cnt; clr wins over any same-cycle update.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      ovf_d     = ovf_q;
      if (clr) begin
         sat_cnt_d = '0;
         ovf_d     = 1'b0;
      end else begin
         if (vld1_q && sat_s && sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
         if (drop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign sat_cnt  = sat_cnt_q;
   assign ovf_flag = ovf_q;
endmodule

// File: tb/tb_da_out_stage.sv
// Directed bench for da_out_stage: rounding/saturation table plus FIFO, counter and reset sequences.
module tb_da_out_stage;
   logic        clk_bit = 1'b0;
   logic        rst_n   = 1'b0;
   logic [16:0] sum_in  = '0;
   logic        sum_vld = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_sat;
   logic        ovf_flag;
   logic [7:0]  sat_cnt;
   logic        clr = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int pop_cnt = 0;

   always #5 clk_bit = ~clk_bit;

   da_out_stage dut (
      .clk_bit  (clk_bit),
      .rst_n    (rst_n),
      .sum_in   (sum_in),
      .sum_vld  (sum_vld),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sat  (out_sat),
      .ovf_flag (ovf_flag),
      .sat_cnt  (sat_cnt),
      .clr      (clr)
   );

   always @(negedge clk_bit) if (out_valid && out_ready) pop_cnt++;

   typedef struct {
      logic [16:0] sum;
      logic [7:0]  data;
      logic        sat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [16:0] v);
      @(posedge clk_bit); #1;
      sum_in = v; sum_vld = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_bit); #1;
         sum_vld = 1'b0;
      end
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      @(posedge clk_bit); #1;
      out_ready = 1'b0;
      sum_vld = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk_bit); #1;
      clr = 1'b0;
      sum_vld = 1'b0;
   endtask

   vec_t tbl [14];
   int   n_sat;

   initial begin
      tbl[0]  = '{17'h00080, 8'h01, 1'b0};
      tbl[1]  = '{17'h000C0, 8'h02, 1'b0};
      tbl[2]  = '{17'h1FF40, 8'hFF, 1'b0};
      tbl[3]  = '{17'h00000, 8'h00, 1'b0};
      tbl[4]  = '{17'h1FFC0, 8'h00, 1'b0};
      tbl[5]  = '{17'h0003F, 8'h00, 1'b0};
      tbl[6]  = '{17'h00040, 8'h01, 1'b0};
      tbl[7]  = '{17'h03F80, 8'h7F, 1'b0};
      tbl[8]  = '{17'h03FC0, 8'h7F, 1'b1};
      tbl[9]  = '{17'h1C000, 8'h80, 1'b0};
      tbl[10] = '{17'h1BFC0, 8'h80, 1'b0};
      tbl[11] = '{17'h1BFBF, 8'h80, 1'b1};
      tbl[12] = '{17'h0FF80, 8'h7F, 1'b1};
      tbl[13] = '{17'h10000, 8'h80, 1'b1};

      // reset state
      #2;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_sat",   32'(out_sat),   32'd0);
      chk("rst_ovf",   32'(ovf_flag),  32'd0);
      chk("rst_satcnt",32'(sat_cnt),   32'd0);
      @(posedge clk_bit); #1;
      rst_n = 1'b1;

      // latency: not valid after one edge, valid after two
      drive(17'h00080);
      idle(1);
      @(negedge clk_bit);
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      idle(1);
      @(negedge clk_bit);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_data",  32'(out_data),  32'd1);
      chk("lat_sat",   32'(out_sat),   32'd0);
      pop1();

      // rounding / saturation table
      n_sat = 0;
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].sum);
         idle(2);
         @(negedge clk_bit);
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].data));
         chk($sformatf("tbl%0d_sat", i),   32'(out_sat),   32'(tbl[i].sat));
         if (tbl[i].sat) n_sat++;
         pop1();
         @(negedge clk_bit);
         chk($sformatf("tbl%0d_empty", i), 32'(out_valid), 32'd0);
         chk($sformatf("tbl%0d_zero", i),  32'(out_data),  32'd0);
      end
      chk("tbl_satcnt", 32'(sat_cnt), 32'(n_sat));
      chk("tbl_ovf",    32'(ovf_flag), 32'd0);

      // two saturating results back to back, then clr
      pulse_clr();
      drive(17'h0FF80);
      drive(17'h10000);
      idle(2);
      @(negedge clk_bit);
      chk("sat2_cnt",   32'(sat_cnt),  32'd2);
      chk("sat2_d0",    32'(out_data), 32'h7F);
      chk("sat2_s0",    32'(out_sat),  32'd1);
      pop1();
      @(negedge clk_bit);
      chk("sat2_d1",    32'(out_data), 32'h80);
      chk("sat2_s1",    32'(out_sat),  32'd1);
      pop1();
      pulse_clr();
      @(negedge clk_bit);
      chk("sat2_clr",   32'(sat_cnt),  32'd0);

      // clr coincident with a saturating stage-2 result wins
      drive(17'h0FF80);
      idle(1);
      pulse_clr();
      @(negedge clk_bit);
      chk("clr_prio", 32'(sat_cnt), 32'd0);
      pop1();

      // overflow: 5 pulses into a 4-deep FIFO, drain order 1..4
      pulse_clr();
      for (int k = 1; k <= 5; k++) drive(17'(k * 128));
      idle(2);
      @(negedge clk_bit);
      chk("ovf_flag",  32'(ovf_flag),  32'd1);
      chk("ovf_valid", 32'(out_valid), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_bit);
         chk($sformatf("ovf_drain%0d", k), 32'(out_data), 32'(k));
         pop1();
      end
      @(negedge clk_bit);
      chk("ovf_empty", 32'(out_valid), 32'd0);

      // full FIFO with push and pop in the same cycle: no drop
      pulse_clr();
      for (int k = 1; k <= 4; k++) drive(17'(k * 128));
      idle(2);
      drive(17'(5 * 128));
      idle(1);
      pop1();
      @(negedge clk_bit);
      chk("pp_ovf", 32'(ovf_flag), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk_bit);
         chk($sformatf("pp_drain%0d", k), 32'(out_data), 32'(k));
         pop1();
      end
      @(negedge clk_bit);
      chk("pp_empty", 32'(out_valid), 32'd0);

      // full throughput and sat_cnt saturation at 255
      pulse_clr();
      pop_cnt = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 260; k++) drive(17'h0FF80);
      idle(4);
      @(negedge clk_bit);
      chk("thru_pops",  32'(pop_cnt),  32'd260);
      chk("thru_satcnt",32'(sat_cnt),  32'd255);
      chk("thru_ovf",   32'(ovf_flag), 32'd0);
      out_ready = 1'b0;

      // asynchronous reset with 3 queued entries
      for (int k = 1; k <= 3; k++) drive(17'(k * 128));
      idle(2);
      @(negedge clk_bit);
      chk("arst_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",  32'(out_valid), 32'd0);
      chk("arst_data",   32'(out_data),  32'd0);
      chk("arst_satcnt", 32'(sat_cnt),   32'd0);
      @(posedge clk_bit); #1;
      rst_n = 1'b1;
      drive(17'h000C0);
      idle(1);
      @(negedge clk_bit);
      chk("arst_early", 32'(out_valid), 32'd0);
      idle(1);
      @(negedge clk_bit);
      chk("arst_new_valid", 32'(out_valid), 32'd1);
      chk("arst_new_data",  32'(out_data),  32'd2);
      pop1();
      @(negedge clk_bit);
      chk("arst_only_one", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
